// File: rtl/spi_link_arbiter.sv
// spi_link_arbiter: two-requester round-robin front end for one SPI round-trip link.
// Optional WAIT-state abort is compiled in when SPI_ARB_TIMEOUT_EN is defined.
module spi_link_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [31:0] ERR_WORD       = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rsp_valid0,
  output logic        rsp_valid1,
  output logic [31:0] rsp_data,
  output logic        link_start,
  output logic [31:0] link_data,
  input  logic        link_done,
  input  logic [31:0] link_rsp,
  output logic        busy,
  output logic        timeout_err
);
  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
  state_t      state_q, state_d;
  logic        ptr_q, ptr_d, owner_q, owner_d, win, expire;
  logic [1:0]  gnt_q, gnt_d, rv_q, rv_d;
  logic [31:0] rsp_data_q, rsp_data_d, link_data_q, link_data_d;
  logic        link_start_q, link_start_d, busy_q, busy_d, tout_q, tout_d;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // link_done arriving on the last allowed cycle takes precedence over the abort
  assign expire = state_q == WAIT && !link_done && cnt_q == CNT_LAST;
  assign cnt_d  = state_q == WAIT ? cnt_q + 1'b1 : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_cfg;
  assign expire     = 1'b0;
  assign unused_cfg = ^TIMEOUT_CYCLES;
`endif
  assign win = (req0 & req1) ? ptr_q : req1;
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    link_data_d = link_data_q;
    rsp_data_d  = rsp_data_q;
    gnt_d       = 2'b00;
    rv_d        = 2'b00;
    tout_d      = 1'b0;
    case (state_q)
      IDLE: if (req0 | req1) begin
        state_d     = START;
        owner_d     = win;
        ptr_d       = ~win;
        gnt_d       = win ? 2'b10 : 2'b01;
        link_data_d = win ? data1 : data0;
      end
      START: state_d = WAIT;
      WAIT: if (link_done | expire) begin
        state_d    = IDLE;
        rv_d       = owner_q ? 2'b10 : 2'b01;
        rsp_data_d = link_done ? link_rsp : ERR_WORD;
        tout_d     = expire;
      end
      default: state_d = IDLE;
    endcase
    link_start_d = state_d == START;
    busy_d       = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      owner_q      <= 1'b0;
      gnt_q        <= 2'b00;
      rv_q         <= 2'b00;
      rsp_data_q   <= '0;
      link_data_q  <= '0;
      link_start_q <= 1'b0;
      busy_q       <= 1'b0;
      tout_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      gnt_q        <= gnt_d;
      rv_q         <= rv_d;
      rsp_data_q   <= rsp_data_d;
      link_data_q  <= link_data_d;
      link_start_q <= link_start_d;
      busy_q       <= busy_d;
      tout_q       <= tout_d;
    end
  end
  assign {gnt1, gnt0}             = gnt_q;
  assign {rsp_valid1, rsp_valid0} = rv_q;
  assign rsp_data                 = rsp_data_q;
  assign link_data                = link_data_q;
  assign link_start               = link_start_q;
  assign busy                     = busy_q;
  assign timeout_err              = tout_q;
endmodule

// File: doc/spi_link_arbiter.md
SPI_LINK_ARBITER -- requirements
Module: spi_link_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, max WAIT cycles before abort (compiled with SPI_ARB_TIMEOUT_EN only).
REQ-002 SHALL have parameter ERR_WORD, default 32'hFFFF_FFFF, rsp_data value returned on timeout.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req0/req1  input  1  requester wants one round-trip; held until its gnt.
REQ-006 SHALL have ports data0/data1  input  32  word to send; stable while req high.
REQ-007 SHALL have ports gnt0/gnt1  output  1  one-cycle pulse: request accepted, data captured.
REQ-008 SHALL have ports rsp_valid0/rsp_valid1  output  1  one-cycle pulse: rsp_data valid for that requester.
REQ-009 SHALL have port rsp_data  output  32  shared response word, held until next response.
REQ-010 SHALL have port link_start  output  1  one-cycle pulse launching the SPI round trip.
REQ-011 SHALL have port link_data  output  32  word driven to the link (in_data_A side), held for whole transaction.
REQ-012 SHALL have port link_done  input  1  link completion (done_B_to_A side).
REQ-013 SHALL have port link_rsp  input  32  reply word from the link, valid when link_done high.
REQ-014 SHALL have ports busy  output  1  high in START/WAIT; timeout_err  output  1  one-cycle abort pulse.

Function
REQ-015 SHALL implement FSM IDLE -> START -> WAIT -> IDLE; all outputs registered.
REQ-016 In IDLE with any req high at edge: next cycle state=START, gnt of winner=1, link_data=winner's data, owner recorded.
REQ-017 In START: link_start=1 for exactly that cycle; next state WAIT.
REQ-018 In WAIT with link_done high at edge: rsp_data<=link_rsp, rsp_valid[owner]=1 next cycle, state IDLE.
REQ-019 A new request SHALL be acceptable in the IDLE cycle carrying rsp_valid (back-to-back, no bubble beyond that).
REQ-020 Arbitration SHALL be round-robin: priority pointer moves to the non-owner at each grant; both req high -> pointer holder wins.
REQ-021 Single requester SHALL be granted regardless of pointer.
REQ-022 req dropped before gnt SHALL be treated as withdrawn, no side effects.
REQ-023 link_done outside WAIT SHALL be ignored; req during START/WAIT SHALL be held off (no gnt).
REQ-024 gnt0/gnt1 and rsp_valid0/rsp_valid1 SHALL each be mutually exclusive (one-hot or zero).
REQ-025 Latency req-to-gnt = 1 cycle from IDLE; link_done-to-rsp_valid = 1 cycle.

Reset
REQ-026 rst high SHALL immediately force IDLE, pointer to requester 0, all outputs (gnt, rsp_valid, rsp_data, link_start, link_data, busy, timeout_err) to 0.
REQ-027 Reset mid-transaction SHALL abandon it silently: no rsp_valid, later link_done ignored until a new WAIT.

Configuration
REQ-028 With SPI_ARB_TIMEOUT_EN defined: counter cleared on WAIT entry; link_done absent for TIMEOUT_CYCLES WAIT cycles -> timeout_err=1, rsp_valid[owner]=1, rsp_data=ERR_WORD, state IDLE, all one cycle later.
REQ-029 With SPI_ARB_TIMEOUT_EN defined, link_done on the final timeout cycle SHALL win (normal response, no timeout_err).
REQ-030 Without SPI_ARB_TIMEOUT_EN: no counter, WAIT indefinitely, timeout_err tied 0.

Verification
REQ-031 req0=1, data0=32'h42C8_0000, link model replies data+1 after 10 cycles -> gnt0 pulse, link_data=32'h42C8_0000, one link_start, rsp_valid0 with rsp_data=32'h42C8_0001.
REQ-032 req0 and req1 both high first cycle after reset (data 32'h1, 32'h2) -> req0 served first (rsp 32'h2), then req1 (rsp 32'h3).
REQ-033 req0, req1 held continuously over 4 transactions -> grant order 0,1,0,1; no gnt during busy.
REQ-034 Macro defined, TIMEOUT_CYCLES=64, link_done never asserted -> timeout_err and rsp_valid0 exactly 65 cycles after link_start, rsp_data=32'hFFFF_FFFF; macro undefined -> busy stays 1.
REQ-035 rst asserted 5 cycles into WAIT, link_done pulsed 3 cycles after release -> all outputs 0, no rsp_valid, state IDLE.
